// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, fetch queue, LI merging and redirect handling; define FETCH_HALT_EN to stop fetching on the halt word
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_ir,
    output logic [15:0] out_imm,
    output logic [15:0] out_pc,
    output logic        halted
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [15:0]   q_word [DEPTH];
    logic [15:0]   q_addr [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, pop_n, occ;
    logic [15:0]   pc, fill_addr, head_word, next_word;
    logic          inflight, halt_seen, redir, head_li, fire, push;

    // head decode, handshake, issue and fill decisions
    always_comb begin
        head_word = q_word[rd_ptr];
        next_word = q_word[rd_ptr + PW'(1)];
        head_li   = head_word[15:12] == 4'hA;
        out_valid = !halted && (head_li ? count >= CW'(2) : count != '0);
        out_ir    = out_valid ? head_word : 16'h0000;
        out_imm   = out_valid && head_li ? next_word : 16'h0000;
        out_pc    = out_valid ? q_addr[rd_ptr] : 16'h0000;
        redir     = redirect_valid && !halted;
        fire      = out_valid && out_ready && !redir;
        pop_n     = fire ? (head_li ? CW'(2) : CW'(1)) : '0;
        occ       = count + CW'(inflight) - pop_n;
        imem_rd   = rst_n && !halted && !halt_seen && !redirect_valid && occ < FULL;
        imem_addr = pc;
        push      = inflight && !redir && !halt_seen;
    end

    // PC, queue pointers and occupancy; a redirect flushes everything and kills the read in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            inflight  <= 1'b0;
            fill_addr <= 16'h0000;
        end else begin
            inflight  <= imem_rd;
            fill_addr <= pc;
            if (redir) begin
                pc     <= redirect_pc;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (imem_rd) pc <= pc + 16'd1;
                if (push) wr_ptr <= wr_ptr + PW'(1);
                rd_ptr <= rd_ptr + pop_n[PW-1:0];
                count  <= count + CW'(push) - pop_n;
            end
        end
    end

    // queue storage: returning word tagged with the address it was fetched from
    always_ff @(posedge clk) begin
        if (push) begin
            q_word[wr_ptr] <= imem_data;
            q_addr[wr_ptr] <= fill_addr;
        end
    end

`ifdef FETCH_HALT_EN
    // halt word pushed stops issue and fill; halted rises once that word has been handed downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_seen <= 1'b0;
            halted    <= 1'b0;
        end else begin
            if (redir) halt_seen <= 1'b0;
            else if (push && imem_data == 16'h0000) halt_seen <= 1'b1;
            if (fire && head_word == 16'h0000) halted <= 1'b1;
        end
    end
`else
    assign halt_seen = 1'b0;
    assign halted    = 1'b0;
`endif
endmodule
